matmul_job_scheduler: RTL and testbench

Sequences the 8x8 `matrix_multiplication` engine on behalf of a host. Accepts queued jobs: base addresses for A, B and C, plus a tag. Launches each job with a level start and holds it until the engine's done. Then runs the clear_done handshake and returns a tagged completion with a timeout/error flag. Sits between the host command interface and the engine's `start_reg`/`clear_done_reg`/`done_mat_mul` pins, all on one clock domain.

---
 rtl/matmul_sched_pkg.sv | 23 ++
 rtl/matmul_cmd_fifo.sv | 58 +++++
 rtl/matmul_job_scheduler.sv | 144 ++++++++++++++
 tb/tb_matmul_job_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_sched_pkg.sv
// Shared types and default widths for the matmul job scheduler.
package matmul_sched_pkg;

    localparam int unsigned DEF_AW      = 10;
    localparam int unsigned DEF_TW      = 4;
    localparam int unsigned DEF_DEPTH   = 4;
    localparam int unsigned DEF_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StClear = 2'd2
    } state_e;

    // Job record at the default widths; the top re-declares it at its own widths.
    typedef struct packed {
        logic [DEF_AW-1:0] addr_a;
        logic [DEF_AW-1:0] addr_b;
        logic [DEF_AW-1:0] addr_c;
        logic [DEF_TW-1:0] tag;
    } job_t;

endpackage

// File: rtl/matmul_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit to tell full from empty.
module matmul_cmd_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty,
    output logic         empty_next
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
    logic         push_ok, pop_ok, full_next;

    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr[PW-1:0]];

    // Next pointer values and the flags they imply.
    always_comb begin
        wr_ptr_d   = wr_ptr + (PW+1)'(push_ok);
        rd_ptr_d   = rd_ptr + (PW+1)'(pop_ok);
        empty_next = (wr_ptr_d == rd_ptr_d);
        full_next  = (wr_ptr_d[PW] != rd_ptr_d[PW]) &&
                     (wr_ptr_d[PW-1:0] == rd_ptr_d[PW-1:0]);
    end

    // Pointer and flag registers; reset discards all queued entries.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_d;
            rd_ptr <= rd_ptr_d;
            full   <= full_next;
            empty  <= empty_next;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[PW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/matmul_job_scheduler.sv
// Queues host jobs and sequences the 8x8 matmul engine: start, wait for done or timeout,
// clear_done handshake, then a tagged completion.
module matmul_job_scheduler
    import matmul_sched_pkg::*;
#(
    parameter int unsigned AW      = DEF_AW,
    parameter int unsigned TW      = DEF_TW,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr_a,
    input  logic [AW-1:0] cmd_addr_b,
    input  logic [AW-1:0] cmd_addr_c,
    input  logic [TW-1:0] cmd_tag,
    output logic          mm_start,
    output logic          mm_clear_done,
    output logic [AW-1:0] mm_addr_a,
    output logic [AW-1:0] mm_addr_b,
    output logic [AW-1:0] mm_addr_c,
    input  logic          mm_done,
    output logic          cpl_valid,
    input  logic          cpl_ready,
    output logic [TW-1:0] cpl_tag,
    output logic          cpl_err,
    output logic          busy,
    output logic [15:0]   jobs_done,
    output logic [7:0]    err_count
);

    localparam int unsigned TMW = $clog2(TIMEOUT);
    localparam logic [TMW-1:0] TLAST = TMW'(TIMEOUT - 1);

    typedef struct packed {
        logic [AW-1:0] addr_a;
        logic [AW-1:0] addr_b;
        logic [AW-1:0] addr_c;
        logic [TW-1:0] tag;
    } job_rec_t;

    state_e   state;
    job_rec_t push_job, pop_job;
    logic     fifo_full, fifo_empty, fifo_empty_next, pop;
    logic [TMW-1:0] timer;
    logic [TW-1:0]  cur_tag;
    logic           cur_err;

    assign push_job  = '{addr_a: cmd_addr_a, addr_b: cmd_addr_b, addr_c: cmd_addr_c,
                         tag: cmd_tag};
    assign cmd_ready = ~fifo_full;
    // A pending completion only blocks the pop, and only until the host takes it.
    assign pop       = (state == StIdle) && !fifo_empty && (!cpl_valid || cpl_ready);

    matmul_cmd_fifo #(
        .W     ($bits(job_rec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (cmd_valid),
        .push_data  (push_job),
        .pop        (pop),
        .pop_data   (pop_job),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .empty_next (fifo_empty_next)
    );

    // Scheduler FSM with registered engine controls, completion and counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= StIdle;
            mm_start      <= 1'b0;
            mm_clear_done <= 1'b0;
            mm_addr_a     <= '0;
            mm_addr_b     <= '0;
            mm_addr_c     <= '0;
            cur_tag       <= '0;
            cur_err       <= 1'b0;
            timer         <= '0;
            cpl_valid     <= 1'b0;
            cpl_tag       <= '0;
            cpl_err       <= 1'b0;
            busy          <= 1'b0;
            jobs_done     <= '0;
            err_count     <= '0;
        end else begin
            if (cpl_valid && cpl_ready) begin
                cpl_valid <= 1'b0;
            end
            case (state)
                StIdle: begin
                    if (pop) begin
                        mm_addr_a <= pop_job.addr_a;
                        mm_addr_b <= pop_job.addr_b;
                        mm_addr_c <= pop_job.addr_c;
                        cur_tag   <= pop_job.tag;
                        timer     <= '0;
                        mm_start  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= StRun;
                    end else begin
                        busy <= !fifo_empty_next;
                    end
                end
                StRun: begin
                    // Done takes priority over a coincident timeout.
                    if (mm_done) begin
                        cur_err       <= 1'b0;
                        mm_start      <= 1'b0;
                        mm_clear_done <= 1'b1;
                        state         <= StClear;
                    end else if (timer == TLAST) begin
                        cur_err       <= 1'b1;
                        mm_start      <= 1'b0;
                        mm_clear_done <= 1'b1;
                        state         <= StClear;
                    end else begin
                        timer <= timer + TMW'(1);
                    end
                end
                StClear: begin
                    if (!mm_done) begin
                        mm_clear_done <= 1'b0;
                        cpl_valid     <= 1'b1;
                        cpl_tag       <= cur_tag;
                        cpl_err       <= cur_err;
                        jobs_done     <= jobs_done + 16'd1;
                        if (cur_err && (err_count != 8'hFF)) begin
                            err_count <= err_count + 8'd1;
                        end
                        busy  <= !fifo_empty_next;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_job_scheduler.sv
// Scoreboard bench for matmul_job_scheduler with a behavioural engine model.
module tb_matmul_job_scheduler;

    localparam int AW      = 10;
    localparam int TW      = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr_a = '0, cmd_addr_b = '0, cmd_addr_c = '0;
    logic [TW-1:0] cmd_tag = '0;
    logic          mm_start, mm_clear_done;
    logic [AW-1:0] mm_addr_a, mm_addr_b, mm_addr_c;
    logic          mm_done = 1'b0;
    logic          cpl_valid;
    logic          cpl_ready = 1'b1;
    logic [TW-1:0] cpl_tag;
    logic          cpl_err;
    logic          busy;
    logic [15:0]   jobs_done;
    logic [7:0]    err_count;

    always #5 clk = ~clk;

    matmul_job_scheduler #(
        .AW      (AW),
        .TW      (TW),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr_a    (cmd_addr_a),
        .cmd_addr_b    (cmd_addr_b),
        .cmd_addr_c    (cmd_addr_c),
        .cmd_tag       (cmd_tag),
        .mm_start      (mm_start),
        .mm_clear_done (mm_clear_done),
        .mm_addr_a     (mm_addr_a),
        .mm_addr_b     (mm_addr_b),
        .mm_addr_c     (mm_addr_c),
        .mm_done       (mm_done),
        .cpl_valid     (cpl_valid),
        .cpl_ready     (cpl_ready),
        .cpl_tag       (cpl_tag),
        .cpl_err       (cpl_err),
        .busy          (busy),
        .jobs_done     (jobs_done),
        .err_count     (err_count)
    );

    typedef struct {
        int tag;
        int err;
        int slen;
    } exp_t;

    exp_t sb[$];
    int   slen_q[$];
    int   clen_q[$];
    int   lat_map[int];
    int   b_map[int];
    int   c_map[int];
    int   n_checks = 0;
    int   n_pass = 0;
    int   exp_jobs = 0;
    int   exp_errs = 0;

    task automatic check_eq(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Engine: done after lat start cycles (lat 0 = never), dropped once clear_done is seen.
    initial begin
        int cnt;
        int a;
        cnt = 0;
        forever begin
            @(negedge clk);
            a = int'(mm_addr_a);
            if (!resetn) begin
                cnt = 0;
                mm_done = 1'b0;
            end else if (mm_clear_done) begin
                cnt = 0;
                mm_done = 1'b0;
            end else if (mm_start && !mm_done) begin
                if (cnt == 0) begin
                    if (!lat_map.exists(a)) begin
                        check_eq("mm_addr_a_known", 0, 1);
                    end else begin
                        check_eq("mm_addr_b", mm_addr_b, b_map[a]);
                        check_eq("mm_addr_c", mm_addr_c, c_map[a]);
                    end
                end
                cnt++;
                if (lat_map.exists(a) && lat_map[a] != 0 && cnt == lat_map[a]) mm_done = 1'b1;
            end else begin
                cnt = 0;
            end
        end
    end

    // Pulse-length tracker and completion checker.
    initial begin
        int   srun;
        int   crun;
        exp_t e;
        srun = 0;
        crun = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                srun = 0;
                crun = 0;
                slen_q.delete();
                clen_q.delete();
            end else begin
                if (mm_start) srun++;
                else if (srun != 0) begin slen_q.push_back(srun); srun = 0; end
                if (mm_clear_done) crun++;
                else if (crun != 0) begin clen_q.push_back(crun); crun = 0; end
                if (cpl_valid && cpl_ready) begin
                    if (sb.size() == 0) begin
                        check_eq("unexpected_cpl", cpl_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        exp_jobs++;
                        if (e.err != 0 && exp_errs < 255) exp_errs++;
                        check_eq("cpl_tag", cpl_tag, e.tag);
                        check_eq("cpl_err", cpl_err, e.err);
                        check_eq("jobs_done", jobs_done, exp_jobs);
                        check_eq("err_count", err_count, exp_errs);
                        check_eq("busy_at_cpl", busy, (sb.size() != 0));
                        if (slen_q.size() == 0) check_eq("start_seen", slen_q.size(), 1);
                        else check_eq("start_len", slen_q.pop_front(), e.slen);
                        if (clen_q.size() == 0) check_eq("clear_seen", clen_q.size(), 1);
                        else check_eq("clear_len", clen_q.pop_front(), 1);
                    end
                end
            end
        end
    end

    // Offers one command and holds it until accepted; ends at the next drive point.
    task automatic push_job(input int a, input int b, input int c, input int tag, input int lat);
        bit   ok;
        exp_t e;
        lat_map[a] = lat;
        b_map[a]   = b;
        c_map[a]   = c;
        cmd_valid  = 1'b1;
        cmd_addr_a = a[AW-1:0];
        cmd_addr_b = b[AW-1:0];
        cmd_addr_c = c[AW-1:0];
        cmd_tag    = tag[TW-1:0];
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check_eq("push_ready", cmd_ready, 1);
        @(posedge clk);
        #2;
        if (ok) begin
            e.tag  = tag;
            e.err  = (lat == 0 || lat > TIMEOUT) ? 1 : 0;
            e.slen = (lat == 0 || lat > TIMEOUT) ? TIMEOUT : lat;
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain(input int maxc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !cpl_valid && !busy) begin done = 1'b1; break; end
        end
        if (!done) check_eq("drain", {sb.size() != 0, cpl_valid, busy}, 0);
        @(posedge clk);
        #2;
    endtask

    initial begin
        int  hits;
        bit  seen;
        // Reset state
        #12;
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_mm_start", mm_start, 0);
        check_eq("rst_mm_clear", mm_clear_done, 0);
        check_eq("rst_cpl_valid", cpl_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_jobs_done", jobs_done, 0);
        check_eq("rst_err_count", err_count, 0);
        check_eq("rst_addrs", {mm_addr_a, mm_addr_b, mm_addr_c}, 0);
        check_eq("rst_cpl_tag", {cpl_tag, cpl_err}, 0);
        @(posedge clk);
        #2;
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // Single job: pop on t+1, start from t+2
        push_job(32'h000, 32'h040, 32'h080, 3, 10);
        cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("start_t1", mm_start, 0);
        @(negedge clk);
        check_eq("start_t2", mm_start, 1);
        wait_drain(100);

        // Back-to-back: five commands while job 0 runs
        push_job(32'h100, 32'h140, 32'h180, 0, 12);
        push_job(32'h104, 32'h144, 32'h184, 1, 3);
        push_job(32'h108, 32'h148, 32'h188, 2, 3);
        push_job(32'h10C, 32'h14C, 32'h18C, 3, 3);
        push_job(32'h110, 32'h150, 32'h190, 4, 3);
        @(negedge clk);
        check_eq("full_cmd_ready", cmd_ready, 0);
        check_eq("full_busy", busy, 1);
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
        wait_drain(400);

        // Timeout, then a normal job
        push_job(32'h200, 32'h240, 32'h280, 5, 0);
        push_job(32'h204, 32'h244, 32'h284, 6, 4);
        cmd_valid = 1'b0;
        wait_drain(200);

        // Done on the same cycle as the last timer count
        push_job(32'h300, 32'h340, 32'h380, 7, TIMEOUT);
        cmd_valid = 1'b0;
        wait_drain(200);

        // Host stalls the completion with a second job queued
        cpl_ready = 1'b0;
        push_job(32'h3F0, 32'h040, 32'h044, 8, 3);
        push_job(32'h3F4, 32'h048, 32'h04C, 9, 3);
        cmd_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cpl_valid) begin seen = 1'b1; break; end
        end
        if (!seen) check_eq("cpl_wait", cpl_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("hold_cpl_valid", cpl_valid, 1);
            check_eq("hold_cpl_tag", cpl_tag, 8);
            check_eq("hold_no_launch", mm_start, 0);
        end
        @(posedge clk);
        #2;
        cpl_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("launch_after_ready", mm_start, 1);
        wait_drain(200);

        // Reset during RUN with jobs queued
        push_job(32'h0A0, 32'h0B0, 32'h0C0, 10, 0);
        push_job(32'h0A4, 32'h0B4, 32'h0C4, 11, 3);
        push_job(32'h0A8, 32'h0B8, 32'h0C8, 12, 3);
        cmd_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mm_start) begin seen = 1'b1; break; end
        end
        check_eq("run_before_reset", mm_start, 1);
        @(negedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check_eq("rst_run_mm_start", mm_start, 0);
        check_eq("rst_run_cmd_ready", cmd_ready, 1);
        check_eq("rst_run_busy", busy, 0);
        check_eq("rst_run_counters", {jobs_done, err_count}, 0);
        check_eq("rst_run_cpl_valid", cpl_valid, 0);
        sb.delete();
        exp_jobs = 0;
        exp_errs = 0;
        repeat (2) @(posedge clk);
        #2;
        resetn = 1'b1;
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mm_start || cpl_valid || busy) hits++;
        end
        check_eq("post_reset_idle", hits, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
